// File: rtl/cache_memory_transfer_engine.sv
// Cache-to-memory transfer engine.
// Takes one block fetch or one dirty-block writeback from the cache controller.
// The block moves over a valid/ready memory bus as MEM_BUS_WIDTH-bit beats.
// Beat 0 carries the least significant slice of the block.
// Fetched beats are reassembled and presented as a whole block with a done pulse.
//
// state        | meaning
// -------------+---------------------------------------------------------
// S_IDLE       | waiting for a request, reqReady high
// S_WB_CMD     | write command offered, waiting for memCmdReady
// S_WB_DATA    | streaming writeback beats, cnt selects the slice
// S_FETCH_CMD  | read command offered, waiting for memCmdReady
// S_FETCH_DATA | collecting read beats into the assembly register
module cache_memory_transfer_engine #(
    parameter int BLOCK_SIZE    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int MEM_BUS_WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       fetchReq,
    input  logic [ADDRESS_WIDTH-1:0]   fetchAddress,
    input  logic                       writeBackReq,
    input  logic [ADDRESS_WIDTH-1:0]   writeBackAddress,
    input  logic [8*BLOCK_SIZE-1:0]    writeBackData,
    output logic                       reqReady,
    output logic [8*BLOCK_SIZE-1:0]    fetchedData,
    output logic                       fetchDone,
    output logic                       writeBackDone,
    output logic                       memCmdValid,
    input  logic                       memCmdReady,
    output logic                       memCmdWrite,
    output logic [ADDRESS_WIDTH-1:0]   memCmdAddress,
    output logic                       memWdataValid,
    input  logic                       memWdataReady,
    output logic [MEM_BUS_WIDTH-1:0]   memWdata,
    output logic                       memWdataLast,
    input  logic                       memRdataValid,
    output logic                       memRdataReady,
    input  logic [MEM_BUS_WIDTH-1:0]   memRdata,
    input  logic                       memRdataLast,
    output logic                       protocolError
);

    localparam int BLOCK_BITS = 8 * BLOCK_SIZE;
    localparam int BEATS      = BLOCK_BITS / MEM_BUS_WIDTH;
    localparam int CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [CNT_W-1:0]         LAST_CNT    = CNT_W'(BEATS - 1);
    localparam logic [ADDRESS_WIDTH-1:0] OFFSET_MASK = ADDRESS_WIDTH'(BLOCK_SIZE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WB_CMD,
        S_WB_DATA,
        S_FETCH_CMD,
        S_FETCH_DATA
    } state_t;

    state_t state;
    state_t state_next;

    logic [CNT_W-1:0]                          cnt;
    logic                                      awake;
    logic [ADDRESS_WIDTH-1:0]                  addr_q;
    logic [BEATS-1:0][MEM_BUS_WIDTH-1:0]       wb_q;
    logic [BEATS-1:0][MEM_BUS_WIDTH-1:0]       asm_q;
    logic [BEATS-1:0][MEM_BUS_WIDTH-1:0]       asm_next;
    logic [BLOCK_BITS-1:0]                     fetched_q;
    logic                                      wb_done_q;
    logic                                      fetch_done_q;
    logic                                      proto_err_q;

    logic accept_wb;
    logic accept_fetch;
    logic cmd_fire;
    logic wbeat_fire;
    logic rbeat_fire;
    logic cnt_last;
    logic req_ready;
    logic cmd_valid;
    logic cmd_write;
    logic wdata_valid;
    logic rdata_ready;

    assign cnt_last = (cnt == LAST_CNT);

    // State register; reset aborts any transfer in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode, handshake strobes and bus control outputs.
    always_comb begin
        state_next   = state;
        req_ready    = 1'b0;
        cmd_valid    = 1'b0;
        cmd_write    = 1'b0;
        wdata_valid  = 1'b0;
        rdata_ready  = 1'b0;
        accept_wb    = 1'b0;
        accept_fetch = 1'b0;
        cmd_fire     = 1'b0;
        wbeat_fire   = 1'b0;
        rbeat_fire   = 1'b0;
        case (state)
            S_IDLE: begin
                // awake keeps reqReady low at the instant reset is released
                req_ready = awake;
                if (awake && writeBackReq) begin
                    // writeback wins; a concurrent fetch stays pending
                    accept_wb  = 1'b1;
                    state_next = S_WB_CMD;
                end else if (awake && fetchReq) begin
                    accept_fetch = 1'b1;
                    state_next   = S_FETCH_CMD;
                end
            end
            S_WB_CMD: begin
                cmd_valid = 1'b1;
                cmd_write = 1'b1;
                if (memCmdReady) begin
                    cmd_fire   = 1'b1;
                    state_next = S_WB_DATA;
                end
            end
            S_WB_DATA: begin
                wdata_valid = 1'b1;
                if (memWdataReady) begin
                    wbeat_fire = 1'b1;
                    if (cnt_last) begin
                        state_next = S_IDLE;
                    end
                end
            end
            S_FETCH_CMD: begin
                cmd_valid = 1'b1;
                if (memCmdReady) begin
                    cmd_fire   = 1'b1;
                    state_next = S_FETCH_DATA;
                end
            end
            S_FETCH_DATA: begin
                rdata_ready = 1'b1;
                if (memRdataValid) begin
                    rbeat_fire = 1'b1;
                    // completion follows the beat count, not memRdataLast
                    if (cnt_last) begin
                        state_next = S_IDLE;
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Assembly register with the current read beat merged into slice cnt.
    always_comb begin
        asm_next      = asm_q;
        asm_next[cnt] = memRdata;
    end

    // Datapath: captured request, beat counter, assembly and completion flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            awake        <= 1'b0;
            cnt          <= '0;
            addr_q       <= '0;
            wb_q         <= '0;
            asm_q        <= '0;
            fetched_q    <= '0;
            wb_done_q    <= 1'b0;
            fetch_done_q <= 1'b0;
            proto_err_q  <= 1'b0;
        end else begin
            awake        <= 1'b1;
            wb_done_q    <= wbeat_fire && cnt_last;
            fetch_done_q <= rbeat_fire && cnt_last;

            if (accept_wb) begin
                addr_q <= writeBackAddress & ~OFFSET_MASK;
                wb_q   <= writeBackData;
            end else if (accept_fetch) begin
                addr_q <= fetchAddress & ~OFFSET_MASK;
            end

            // counter parks at zero after the last beat instead of wrapping
            if (cmd_fire) begin
                cnt <= '0;
            end else if (wbeat_fire || rbeat_fire) begin
                if (cnt_last) begin
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end

            if (rbeat_fire) begin
                asm_q <= asm_next;
                if (cnt_last) begin
                    fetched_q <= asm_next;
                end
                if (memRdataLast != cnt_last) begin
                    proto_err_q <= 1'b1;
                end
            end
        end
    end

    assign reqReady      = req_ready;
    assign memCmdValid   = cmd_valid;
    assign memCmdWrite   = cmd_write;
    assign memCmdAddress = addr_q;
    assign memWdataValid = wdata_valid;
    assign memWdata      = wdata_valid ? wb_q[cnt] : '0;
    assign memWdataLast  = wdata_valid && cnt_last;
    assign memRdataReady = rdata_ready;
    assign fetchedData   = fetched_q;
    assign fetchDone     = fetch_done_q;
    assign writeBackDone = wb_done_q;
    assign protocolError = proto_err_q;

endmodule

// File: tb/tb_cache_memory_transfer_engine.sv
// Directed bench for cache_memory_transfer_engine at default parameters (4 beats).
module tb_cache_memory_transfer_engine;

    logic         clk;
    logic         rst_n;
    logic         fetchReq;
    logic [31:0]  fetchAddress;
    logic         writeBackReq;
    logic [31:0]  writeBackAddress;
    logic [255:0] writeBackData;
    logic         reqReady;
    logic [255:0] fetchedData;
    logic         fetchDone;
    logic         writeBackDone;
    logic         memCmdValid;
    logic         memCmdReady;
    logic         memCmdWrite;
    logic [31:0]  memCmdAddress;
    logic         memWdataValid;
    logic         memWdataReady;
    logic [63:0]  memWdata;
    logic         memWdataLast;
    logic         memRdataValid;
    logic         memRdataReady;
    logic [63:0]  memRdata;
    logic         memRdataLast;
    logic         protocolError;

    cache_memory_transfer_engine dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .fetchReq         (fetchReq),
        .fetchAddress     (fetchAddress),
        .writeBackReq     (writeBackReq),
        .writeBackAddress (writeBackAddress),
        .writeBackData    (writeBackData),
        .reqReady         (reqReady),
        .fetchedData      (fetchedData),
        .fetchDone        (fetchDone),
        .writeBackDone    (writeBackDone),
        .memCmdValid      (memCmdValid),
        .memCmdReady      (memCmdReady),
        .memCmdWrite      (memCmdWrite),
        .memCmdAddress    (memCmdAddress),
        .memWdataValid    (memWdataValid),
        .memWdataReady    (memWdataReady),
        .memWdata         (memWdata),
        .memWdataLast     (memWdataLast),
        .memRdataValid    (memRdataValid),
        .memRdataReady    (memRdataReady),
        .memRdata         (memRdata),
        .memRdataLast     (memRdataLast),
        .protocolError    (protocolError)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    localparam logic N = 1'b0;
    localparam logic Y = 1'b1;

    localparam logic [63:0] R0 = 64'h1111_1111_1111_1111;
    localparam logic [63:0] R1 = 64'h2222_2222_2222_2222;
    localparam logic [63:0] R2 = 64'h3333_3333_3333_3333;
    localparam logic [63:0] R3 = 64'h4444_4444_4444_4444;
    localparam logic [63:0] B0 = 64'h0706_0504_0302_0100;
    localparam logic [63:0] B1 = 64'h0F0E_0D0C_0B0A_0908;
    localparam logic [63:0] B2 = 64'h1716_1514_1312_1110;
    localparam logic [63:0] B3 = 64'h1F1E_1D1C_1B1A_1918;
    localparam logic [63:0] Z  = 64'h0;
    localparam logic [31:0] A0 = 32'h0;

    typedef struct {
        logic        freq;
        logic        wreq;
        logic [31:0] faddr;
        logic [31:0] waddr;
        logic        cmd_rdy;
        logic        wd_rdy;
        logic        rd_vld;
        logic [63:0] rdata;
        logic        rd_last;
        logic        e_req_rdy;
        logic        e_cmd_vld;
        logic        e_cmd_wr;
        logic        e_wd_vld;
        logic [63:0] e_wdata;
        logic        e_wd_last;
        logic        e_rd_rdy;
        logic        e_fdone;
        logic        e_wbdone;
        logic        e_perr;
        logic        chk_addr;
        logic [31:0] e_addr;
    } vec_t;

    vec_t vecs [19];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Feed four read beats; perr_exp[i] is protocolError after beat i is taken.
    task automatic run_beats(input logic [255:0] blk, input logic [3:0] last_mask,
                             input logic [3:0] perr_exp, input string tag);
        for (int i = 0; i < 4; i++) begin
            memRdataValid = 1'b1;
            memRdata      = blk[64*i +: 64];
            memRdataLast  = last_mask[i];
            step();
            chk($sformatf("%s_perr_b%0d", tag, i), protocolError, perr_exp[i]);
        end
        memRdataValid = 1'b0;
        memRdataLast  = 1'b0;
        memRdata      = '0;
    endtask

    logic [255:0] blk;
    int           beats;
    logic         got;
    logic         saw_rd;

    initial begin
        // fetch of 0x1234: command, four beats, done pulse
        vecs[0]  = '{Y,N,32'h1234,A0, N,N,N,Z,N,  Y,N,N,N,Z,N,N,N,N,N, N,A0};
        vecs[1]  = '{N,N,A0,A0,       Y,N,N,Z,N,  N,Y,N,N,Z,N,N,N,N,N, Y,32'h1220};
        vecs[2]  = '{N,N,A0,A0,       N,N,Y,R0,N, N,N,N,N,Z,N,Y,N,N,N, Y,32'h1220};
        vecs[3]  = '{N,N,A0,A0,       N,N,Y,R1,N, N,N,N,N,Z,N,Y,N,N,N, N,A0};
        vecs[4]  = '{N,N,A0,A0,       N,N,Y,R2,N, N,N,N,N,Z,N,Y,N,N,N, N,A0};
        vecs[5]  = '{N,N,A0,A0,       N,N,Y,R3,Y, N,N,N,N,Z,N,Y,N,N,N, N,A0};
        vecs[6]  = '{N,N,A0,A0,       N,N,N,Z,N,  Y,N,N,N,Z,N,N,Y,N,N, Y,32'h1220};
        vecs[7]  = '{N,N,A0,A0,       N,N,N,Z,N,  Y,N,N,N,Z,N,N,N,N,N, N,A0};
        // writeback to 0x40 with memWdataReady toggling
        vecs[8]  = '{N,Y,A0,32'h40,   N,N,N,Z,N,  Y,N,N,N,Z,N,N,N,N,N, N,A0};
        vecs[9]  = '{N,N,A0,A0,       Y,N,N,Z,N,  N,Y,Y,N,Z,N,N,N,N,N, Y,32'h40};
        vecs[10] = '{N,N,A0,A0,       N,Y,N,Z,N,  N,N,N,Y,B0,N,N,N,N,N, N,A0};
        vecs[11] = '{N,N,A0,A0,       N,N,N,Z,N,  N,N,N,Y,B1,N,N,N,N,N, N,A0};
        vecs[12] = '{N,N,A0,A0,       N,Y,N,Z,N,  N,N,N,Y,B1,N,N,N,N,N, N,A0};
        vecs[13] = '{N,N,A0,A0,       N,N,N,Z,N,  N,N,N,Y,B2,N,N,N,N,N, N,A0};
        vecs[14] = '{N,N,A0,A0,       N,Y,N,Z,N,  N,N,N,Y,B2,N,N,N,N,N, N,A0};
        vecs[15] = '{N,N,A0,A0,       N,N,N,Z,N,  N,N,N,Y,B3,Y,N,N,N,N, N,A0};
        vecs[16] = '{N,N,A0,A0,       N,Y,N,Z,N,  N,N,N,Y,B3,Y,N,N,N,N, N,A0};
        vecs[17] = '{N,N,A0,A0,       N,N,N,Z,N,  Y,N,N,N,Z,N,N,N,Y,N, Y,32'h40};
        vecs[18] = '{N,N,A0,A0,       N,N,N,Z,N,  Y,N,N,N,Z,N,N,N,N,N, N,A0};

        for (int i = 0; i < 32; i++) writeBackData[8*i +: 8] = 8'(i);

        rst_n            = 1'b0;
        fetchReq         = 1'b0;
        fetchAddress     = '0;
        writeBackReq     = 1'b0;
        writeBackAddress = '0;
        memCmdReady      = 1'b0;
        memWdataReady    = 1'b0;
        memRdataValid    = 1'b0;
        memRdata         = '0;
        memRdataLast     = 1'b0;

        // reset state
        step();
        step();
        chk("rst_req_ready", reqReady, 1'b0);
        chk("rst_cmd_valid", memCmdValid, 1'b0);
        chk("rst_cmd_addr", memCmdAddress, 32'h0);
        chk("rst_fetched", fetchedData, 256'h0);
        chk("rst_perr", protocolError, 1'b0);
        rst_n = 1'b1;
        #1;
        chk("deassert_req_ready", reqReady, 1'b0);
        step();

        // table-driven fetch and writeback
        for (int r = 0; r < 19; r++) begin
            fetchReq         = vecs[r].freq;
            writeBackReq     = vecs[r].wreq;
            fetchAddress     = vecs[r].faddr;
            writeBackAddress = vecs[r].waddr;
            memCmdReady      = vecs[r].cmd_rdy;
            memWdataReady    = vecs[r].wd_rdy;
            memRdataValid    = vecs[r].rd_vld;
            memRdata         = vecs[r].rdata;
            memRdataLast     = vecs[r].rd_last;
            chk($sformatf("v%0d_req_ready", r), reqReady, vecs[r].e_req_rdy);
            chk($sformatf("v%0d_cmd_valid", r), memCmdValid, vecs[r].e_cmd_vld);
            chk($sformatf("v%0d_cmd_write", r), memCmdWrite, vecs[r].e_cmd_wr);
            chk($sformatf("v%0d_wd_valid", r), memWdataValid, vecs[r].e_wd_vld);
            chk($sformatf("v%0d_wdata", r), memWdata, vecs[r].e_wdata);
            chk($sformatf("v%0d_wd_last", r), memWdataLast, vecs[r].e_wd_last);
            chk($sformatf("v%0d_rd_ready", r), memRdataReady, vecs[r].e_rd_rdy);
            chk($sformatf("v%0d_fetch_done", r), fetchDone, vecs[r].e_fdone);
            chk($sformatf("v%0d_wb_done", r), writeBackDone, vecs[r].e_wbdone);
            chk($sformatf("v%0d_perr", r), protocolError, vecs[r].e_perr);
            if (vecs[r].chk_addr) chk($sformatf("v%0d_cmd_addr", r), memCmdAddress, vecs[r].e_addr);
            step();
        end
        memCmdReady   = 1'b0;
        memWdataReady = 1'b0;
        // fetchedData from the first fetch must survive the writeback
        chk("fetched_block", fetchedData, {R3, R2, R1, R0});

        // simultaneous fetch and writeback: writeback first, fetch stays pending
        fetchReq         = 1'b1;
        fetchAddress     = 32'h2004;
        writeBackReq     = 1'b1;
        writeBackAddress = 32'h301F;
        memCmdReady      = 1'b1;
        memWdataReady    = 1'b1;
        step();
        writeBackReq = 1'b0;
        chk("both_cmd_write", memCmdWrite, 1'b1);
        chk("both_wb_addr", memCmdAddress, 32'h3000);
        beats  = 0;
        got    = 1'b0;
        saw_rd = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (writeBackDone) begin
                got = 1'b1;
                break;
            end
            if (memWdataValid) beats++;
            if (memCmdValid && !memCmdWrite) saw_rd = 1'b1;
        end
        chk("both_wb_done_seen", got, 1'b1);
        chk("both_wb_beats", beats, 4);
        chk("both_no_early_read", saw_rd, 1'b0);
        chk("both_ready_after_wb", reqReady, 1'b1);
        step();
        fetchReq = 1'b0;
        chk("both_read_cmd", memCmdValid, 1'b1);
        chk("both_read_write0", memCmdWrite, 1'b0);
        chk("both_read_addr", memCmdAddress, 32'h2000);
        step();
        chk("both_rd_ready", memRdataReady, 1'b1);
        blk = {8{32'hA5A5_0000 + 32'h1}};
        run_beats(blk, 4'b1000, 4'b0000, "both");
        chk("both_fetch_done", fetchDone, 1'b1);
        chk("both_fetched", fetchedData, blk);
        memCmdReady   = 1'b0;
        memWdataReady = 1'b0;

        // command stall for 5 cycles, then a misplaced memRdataLast
        fetchReq     = 1'b1;
        fetchAddress = 32'h5678;
        step();
        fetchReq     = 1'b0;
        fetchAddress = 32'hFFFF_FFFF;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("stall%0d_cmd_valid", k), memCmdValid, 1'b1);
            chk($sformatf("stall%0d_cmd_addr", k), memCmdAddress, 32'h5660);
            chk($sformatf("stall%0d_rd_ready", k), memRdataReady, 1'b0);
            step();
        end
        memCmdReady = 1'b1;
        step();
        memCmdReady = 1'b0;
        chk("stall_rd_ready", memRdataReady, 1'b1);
        chk("stall_perr_pre", protocolError, 1'b0);
        blk = {64'hDDDD_0000_0000_0004, 64'hCCCC_0000_0000_0003,
               64'hBBBB_0000_0000_0002, 64'hAAAA_0000_0000_0001};
        run_beats(blk, 4'b1010, 4'b1110, "early_last");
        chk("early_last_done", fetchDone, 1'b1);
        chk("early_last_fetched", fetchedData, blk);
        step();
        chk("early_last_done_pulse", fetchDone, 1'b0);
        chk("early_last_sticky", protocolError, 1'b1);

        // reset during writeback beat 2
        writeBackReq     = 1'b1;
        writeBackAddress = 32'h80;
        memCmdReady      = 1'b1;
        memWdataReady    = 1'b1;
        step();
        writeBackReq = 1'b0;
        step();
        step();
        step();
        chk("mid_wb_beat2", memWdata, B2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_wd_valid", memWdataValid, 1'b0);
        chk("mid_rst_wdata", memWdata, 64'h0);
        chk("mid_rst_wd_last", memWdataLast, 1'b0);
        chk("mid_rst_cmd_addr", memCmdAddress, 32'h0);
        chk("mid_rst_fetched", fetchedData, 256'h0);
        chk("mid_rst_perr", protocolError, 1'b0);
        chk("mid_rst_req_ready", reqReady, 1'b0);
        step();
        step();
        rst_n = 1'b1;
        got   = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (writeBackDone || memWdataValid) got = 1'b1;
        end
        chk("mid_rst_no_done", got, 1'b0);
        chk("mid_rst_ready_after", reqReady, 1'b1);

        // memRdataLast never asserted: error flagged on the final beat
        memWdataReady = 1'b0;
        fetchReq      = 1'b1;
        fetchAddress  = 32'h0000_0100;
        step();
        fetchReq = 1'b0;
        chk("nolast_addr", memCmdAddress, 32'h100);
        step();
        memCmdReady = 1'b0;
        blk = {4{64'h0123_4567_89AB_CDEF}};
        run_beats(blk, 4'b0000, 4'b1000, "nolast");
        chk("nolast_done", fetchDone, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_memory_transfer_engine.md
Name: cache_memory_transfer_engine

Overview:
Parametrised cache-to-memory transfer engine between the cache controller and main memory. Accepts one block fetch or one dirty-block writeback from the controller and serialises it into MEM_BUS_WIDTH-bit beats over a valid/ready memory bus. For fetches it reassembles the returned beats into a full block. Supersedes the flat, untimed block signalling with handshaked, multi-beat transfers.

Parameters:
BLOCK_SIZE, 32, cache block size in bytes; power of two, at least 4.
ADDRESS_WIDTH, 32, byte-address width.
MEM_BUS_WIDTH, 64, memory data bus width in bits; must divide 8*BLOCK_SIZE exactly.
BEATS (localparam), 8*BLOCK_SIZE/MEM_BUS_WIDTH, beats per block; at least 1.

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
fetchReq  in  1  controller requests a block fill
fetchAddress  in  ADDRESS_WIDTH  byte address inside the block to fetch
writeBackReq  in  1  controller requests a dirty-block writeback
writeBackAddress  in  ADDRESS_WIDTH  byte address inside the block to write back
writeBackData  in  8*BLOCK_SIZE  block data to write back
reqReady  out  1  engine is idle and accepts a request this cycle
fetchedData  out  8*BLOCK_SIZE  assembled fill block
fetchDone  out  1  one-cycle pulse: fetchedData is valid
writeBackDone  out  1  one-cycle pulse: last writeback beat accepted
memCmdValid  out  1  command valid
memCmdReady  in  1  memory accepts the command
memCmdWrite  out  1  1 = write (writeback), 0 = read (fetch)
memCmdAddress  out  ADDRESS_WIDTH  block-aligned address
memWdataValid  out  1  write beat valid
memWdataReady  in  1  memory accepts the write beat
memWdata  out  MEM_BUS_WIDTH  write beat
memWdataLast  out  1  final write beat
memRdataValid  in  1  read beat valid
memRdataReady  out  1  engine accepts the read beat
memRdata  in  MEM_BUS_WIDTH  read beat
memRdataLast  in  1  memory marks the final read beat
protocolError  out  1  sticky: memRdataLast misaligned with the beat count

Behaviour:
- Reset is asynchronous and active-low. While rst_n=0 and at deassertion, all outputs are 0, fetchedData is 0, state is IDLE and the beat counter is 0. Reset mid-transfer aborts immediately; no done pulse is generated.
- States: IDLE, WB_CMD, WB_DATA, FETCH_CMD, FETCH_DATA.
- IDLE: reqReady=1. A request is captured on the edge where reqReady and the request are both high.
  - If fetchReq and writeBackReq are both high, the writeback wins and goes to WB_CMD. fetchReq is not consumed and must stay high; the fetch is accepted on the first IDLE cycle after writeBackDone.
  - The captured address has its low log2(BLOCK_SIZE) bits forced to 0. Address and writeback data are registered at acceptance; later input changes are ignored.
- WB_CMD: memCmdValid=1, memCmdWrite=1. On memCmdReady, go to WB_DATA with the beat counter at 0.
- WB_DATA: memWdataValid=1, memWdata = block bits [MEM_BUS_WIDTH*(cnt+1)-1 : MEM_BUS_WIDTH*cnt], so beat 0 is the least significant slice. memWdataLast=1 when cnt==BEATS-1.
  - On memWdataReady, cnt increments.
  - On the last accepted beat, writeBackDone pulses on the next cycle and the state returns to IDLE in that same cycle.
- FETCH_CMD: memCmdValid=1, memCmdWrite=0. On memCmdReady, go to FETCH_DATA with cnt at 0.
- FETCH_DATA: memRdataReady=1. Each accepted beat is written into slice cnt of an internal assembly register.
  - After beat BEATS-1: fetchedData is updated in one step from the assembly register, fetchDone pulses the next cycle, and the state returns to IDLE.
  - Between completed fetches, fetchedData holds its value.
- Command, address and write signals stay stable while valid is high and ready is low. Valid is never withdrawn before its handshake.
- protocolError is set (sticky until reset) in either case:
  - memRdataLast=1 on an accepted beat with cnt!=BEATS-1;
  - memRdataLast=0 on beat BEATS-1.
  The transfer still completes on the beat count.
- BEATS==1: memWdataLast is asserted on the single beat and the transfer completes after one beat.
- Outputs outside the active state are 0, except memCmdAddress and fetchedData, which hold their values.
- The beat counter width is clog2(BEATS), minimum 1. It never wraps inside a transfer.

Test Plan:
- Defaults (4 beats). Fetch of 0x0000_1234 with memCmdReady=1 -> memCmdAddress=0x0000_1220, memCmdWrite=0. Beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 with last on beat 3 -> fetchedData={0x44..44,0x33..33,0x22..22,0x11..11}, fetchDone pulses exactly 1 cycle, protocolError=0.
- Writeback to 0x0000_0040, data 256'h(incrementing bytes 0x00..0x1F), memWdataReady toggling 1/0 -> 4 beats, beat 0 = 64'h0706050403020100, memWdataLast only on beat 3, data stable while stalled, one writeBackDone pulse.
- fetchReq and writeBackReq asserted in the same cycle -> full write transfer first, then writeBackDone, then the read command on the next IDLE acceptance.
- memCmdReady held 0 for 5 cycles -> memCmdValid and address held constant; no beats issued until the handshake.
- memRdataLast=1 on beat 1 -> protocolError=1 and remains 1; fetch still completes after 4 beats.
- rst_n low mid-WB_DATA (beat 2) -> outputs 0 immediately (asynchronous), no writeBackDone, reqReady=1 after release.
